// File: rtl/jk_pkg.sv
// Shared types and constants for the JK excitation driver.
// States, JK input codes and don't-care fill policies.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  // {J,K} codes as presented to one flop
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TOG  = 2'b11;

  localparam int DC_ZERO = 0;
  localparam int DC_ONE  = 1;

endpackage

// File: rtl/jk_excite.sv
// Per-bit JK excitation: current q and target t to J/K, zero latency, no flow control.
// policy=1 fills don't-cares with 1 (toggle-preferred), policy=0 fills with 0.
module jk_excite
  import jk_pkg::*;
(
  input  logic q,
  input  logic t,
  input  logic policy,
  output logic j,
  output logic k
);

  logic [1:0] jk;

  always_comb begin
    jk = JK_HOLD;
    unique case ({q, t})
      2'b00:   jk = policy ? JK_RST : JK_HOLD;
      2'b01:   jk = policy ? JK_TOG : JK_SET;
      2'b10:   jk = policy ? JK_TOG : JK_RST;
      default: jk = policy ? JK_SET : JK_HOLD;
    endcase
  end

  assign j = jk[1];
  assign k = jk[0];

endmodule

// File: rtl/jk_excite_driver.sv
// Drives a JK flop bank to each accepted target word; fixed 3-cycle transfer (done at n+3).
// tgt_ready only in IDLE after reset; targets offered while busy wait for the next handshake.
module jk_excite_driver
  import jk_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DC_POLICY = DC_ZERO,
  parameter int CHECK_EN  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] shadow_q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       err_cnt
);

  localparam logic POL = (DC_POLICY == DC_ONE);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] tgt_q, tgt_nxt;
  logic [WIDTH-1:0] j_nxt, k_nxt, shadow_nxt;
  logic [WIDTH-1:0] exc_j, exc_k;
  logic             done_nxt, err_nxt;
  logic [7:0]       cnt_nxt;
  logic             out_of_rst;

  for (genvar i = 0; i < WIDTH; i++) begin : g_exc
    jk_excite u_exc (
      .q      (shadow_q[i]),
      .t      (tgt_data[i]),
      .policy (POL),
      .j      (exc_j[i]),
      .k      (exc_k[i])
    );
  end

  // Ready is held low while in reset and for the edge that releases it
  assign tgt_ready = out_of_rst && (state == IDLE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    tgt_nxt    = tgt_q;
    j_nxt      = '0;
    k_nxt      = '0;
    shadow_nxt = shadow_q;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    cnt_nxt    = err_cnt;
    unique case (state)
      IDLE: begin
        if (tgt_valid && tgt_ready) begin
          tgt_nxt   = tgt_data;
          j_nxt     = exc_j;
          k_nxt     = exc_k;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        shadow_nxt = tgt_q;
        state_nxt  = CHECK;
      end
      CHECK: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
        if ((CHECK_EN != 0) && (q_fb != shadow_q)) begin
          shadow_nxt = q_fb;
          err_nxt    = 1'b1;
          cnt_nxt    = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tgt_q      <= '0;
      j_out      <= '0;
      k_out      <= '0;
      shadow_q   <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= 8'd0;
      out_of_rst <= 1'b0;
    end else begin
      state      <= state_nxt;
      tgt_q      <= tgt_nxt;
      j_out      <= j_nxt;
      k_out      <= k_nxt;
      shadow_q   <= shadow_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
      err_cnt    <= cnt_nxt;
      out_of_rst <= 1'b1;
    end
  end

endmodule
